// File: rtl/sync_link_responder_if.sv
// Camera sync link signal bundle.
//   control_bus_in : sensed master-to-slave open-drain line (0 = request)
//   end_adc        : slave camera end-of-ADC (falling edge = conversion done)
//   feedback_oe    : 1 = pull the feedback line low (acknowledge)
//   rst_cam        : camera reset pulse
//   sample_cam     : camera sampling window
//   busy           : responder is mid-sequence
//   timeout_err    : sticky, last request timed out
//   resp_latency   : WAIT_ADC duration of the last completed request
// The master modport is the side that drives the link inputs and observes the
// responder; the slave modport is the responder itself.
interface sync_link_responder_if #(
  parameter int CNT_W = 8
);
  logic             control_bus_in;
  logic             end_adc;
  logic             feedback_oe;
  logic             rst_cam;
  logic             sample_cam;
  logic             busy;
  logic             timeout_err;
  logic [CNT_W-1:0] resp_latency;

  modport master (
    output control_bus_in, end_adc,
    input  feedback_oe, rst_cam, sample_cam, busy, timeout_err, resp_latency
  );

  modport slave (
    input  control_bus_in, end_adc,
    output feedback_oe, rst_cam, sample_cam, busy, timeout_err, resp_latency
  );
endinterface

// File: rtl/sync_link_responder.sv
// Slave-end responder for the open-drain camera sync link.
// A falling edge on the control line starts a sequence: camera reset pulse,
// sampling window closed by the camera's end-of-ADC falling edge (or a
// timeout), a fixed-width acknowledge pulse on the feedback line, then a wait
// for the master to release the control line.
// Ports:
//   pix_clk   : single clock
//   rst_FSM_n : asynchronous active-low reset
//   link      : sync_link_responder_if.slave (see interface for signal list)
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | waiting for a control-line falling edge
// RESET_CAM | rst_cam asserted for RST_CYCLES cycles
// WAIT_ADC  | sample_cam asserted, latency counter running
// ACK       | feedback line pulled low for ACK_CYCLES cycles
// RELEASE   | waiting for the master to release the control line
module sync_link_responder #(
  parameter int SYNC_STAGES = 2,
  parameter int RST_CYCLES  = 4,
  parameter int ACK_CYCLES  = 3,
  parameter int TIMEOUT     = 200,
  parameter int CNT_W       = 8
) (
  input logic                  pix_clk,
  input logic                  rst_FSM_n,
  sync_link_responder_if.slave link
);

  typedef enum logic [2:0] {
    IDLE,
    RESET_CAM,
    WAIT_ADC,
    ACK,
    RELEASE
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] ACK_LAST    = CNT_W'(ACK_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

  logic [SYNC_STAGES-1:0] ctrl_sync;
  logic [SYNC_STAGES-1:0] adc_sync;
  logic                   ctrl_prev;
  logic                   adc_prev;
  logic                   ctrl_lvl;
  logic                   adc_lvl;
  logic                   ctrl_fall;
  logic                   adc_fall;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] lat_q;
  logic [CNT_W-1:0] lat_nxt;
  logic             terr_q;
  logic             terr_nxt;
  logic             fb_q;
  logic             rst_cam_q;
  logic             sample_q;
  logic             busy_q;

  // Both lines idle high, so the synchronizers reset to 1 to avoid a false
  // edge right after reset.
  always_ff @(posedge pix_clk or negedge rst_FSM_n) begin
    if (!rst_FSM_n) begin
      ctrl_sync <= '1;
      adc_sync  <= '1;
      ctrl_prev <= 1'b1;
      adc_prev  <= 1'b1;
    end else begin
      ctrl_sync <= {ctrl_sync[SYNC_STAGES-2:0], link.control_bus_in};
      adc_sync  <= {adc_sync[SYNC_STAGES-2:0], link.end_adc};
      ctrl_prev <= ctrl_sync[SYNC_STAGES-1];
      adc_prev  <= adc_sync[SYNC_STAGES-1];
    end
  end

  assign ctrl_lvl  = ctrl_sync[SYNC_STAGES-1];
  assign adc_lvl   = adc_sync[SYNC_STAGES-1];
  assign ctrl_fall = ctrl_prev & ~ctrl_lvl;
  assign adc_fall  = adc_prev & ~adc_lvl;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    lat_nxt   = lat_q;
    terr_nxt  = terr_q;
    case (state)
      IDLE: begin
        if (ctrl_fall) begin
          state_nxt = RESET_CAM;
          cnt_nxt   = '0;
          terr_nxt  = 1'b0;
        end
      end
      RESET_CAM: begin
        if (cnt == RST_LAST) begin
          state_nxt = WAIT_ADC;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      WAIT_ADC: begin
        // ADC completion takes priority over a coincident timeout.
        if (adc_fall) begin
          state_nxt = ACK;
          lat_nxt   = cnt;
          cnt_nxt   = '0;
        end else if (cnt == TIMEOUT_CNT) begin
          state_nxt = RELEASE;
          terr_nxt  = 1'b1;
          lat_nxt   = '1;
          cnt_nxt   = '0;
        end else if (cnt != CNT_MAX) begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      ACK: begin
        if (cnt == ACK_LAST) begin
          state_nxt = RELEASE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      RELEASE: begin
        // Only a released line re-arms the detector; a held-low line cannot
        // retrigger.
        if (ctrl_lvl) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge pix_clk or negedge rst_FSM_n) begin
    if (!rst_FSM_n) begin
      state     <= IDLE;
      cnt       <= '0;
      lat_q     <= '0;
      terr_q    <= 1'b0;
      fb_q      <= 1'b0;
      rst_cam_q <= 1'b0;
      sample_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      lat_q     <= lat_nxt;
      terr_q    <= terr_nxt;
      fb_q      <= (state_nxt == ACK);
      rst_cam_q <= (state_nxt == RESET_CAM);
      sample_q  <= (state_nxt == WAIT_ADC);
      busy_q    <= (state_nxt != IDLE);
    end
  end

  assign link.feedback_oe  = fb_q;
  assign link.rst_cam      = rst_cam_q;
  assign link.sample_cam   = sample_q;
  assign link.busy         = busy_q;
  assign link.timeout_err  = terr_q;
  assign link.resp_latency = lat_q;

endmodule
